fb_arbiter: RTL and testbench

Single-port arbiter and clear sequencer for the 1-bit-per-pixel video buffer (VGA_WIDTH × VGA_HEIGHT entries) that the pixel generator scans. Three agents share the single RAM port:
- the display read path, which always wins;
- an internal clear engine, which fills the whole buffer with a constant;
- a host write port (valid/ready), used by UART/SPI image loaders.

It sits between those agents and a synchronous 1-cycle-latency single-port RAM.

---
 rtl/fb_arbiter.sv | 156 +++++++++++++++
 tb/tb_fb_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port RAM arbiter for the 1bpp video buffer.
// Display reads always win, the clear engine fills the buffer when the
// display is idle, and the host write port gets whatever slots remain.
module fb_arbiter #(
    parameter int VGA_WIDTH  = 640,
    parameter int VGA_HEIGHT = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_valid,
    output logic                  disp_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_data,
    output logic                  wr_err,
    input  logic                  clr_start,
    input  logic                  clr_value,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wdata,
    input  logic                  mem_rdata
);

    localparam int                    BUFFER_SIZE = VGA_WIDTH * VGA_HEIGHT;
    localparam logic [ADDR_WIDTH:0]   BUF_LIMIT   = (ADDR_WIDTH + 1)'(BUFFER_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(BUFFER_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_val_q, clr_val_d;
    logic                  clr_busy_q, clr_busy_d;
    logic                  clr_done_q, clr_done_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_oob_q, rd_oob_d;
    logic                  disp_valid_q, disp_valid_d;
    logic                  disp_data_q, disp_data_d;
    logic                  wr_err_q, wr_err_d;

    logic disp_oob, wr_oob;
    logic disp_grant, clr_grant, host_grant, wr_ready_c;

    // Grant decode: display first, then clear engine, then host.
    always_comb begin
        disp_oob   = {1'b0, disp_addr} >= BUF_LIMIT;
        wr_oob     = {1'b0, wr_addr} >= BUF_LIMIT;
        disp_grant = disp_req & ~rst;
        clr_grant  = (state_q == ST_CLEAR) & ~disp_req & ~rst;
        wr_ready_c = (state_q == ST_IDLE) & ~disp_req & ~clr_start & ~rst;
        host_grant = wr_valid & wr_ready_c;
    end

    // RAM port drive; out-of-range accesses keep the address but never enable the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 1'b0;
        if (disp_grant) begin
            mem_en   = ~disp_oob;
            mem_addr = disp_addr;
        end else if (clr_grant) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = clr_val_q;
        end else if (host_grant) begin
            mem_en    = ~wr_oob;
            mem_we    = ~wr_oob;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    // Clear sequencer next state; the counter only advances on cycles it owns the port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_val_d = clr_val_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    cnt_d     = '0;
                    clr_val_d = clr_value;
                end
            end
            ST_CLEAR: begin
                if (clr_grant) begin
                    if (cnt_q == LAST_ADDR) state_d = ST_DONE;
                    else                    cnt_d   = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        clr_busy_d = (state_d == ST_CLEAR);
        clr_done_d = (state_d == ST_DONE);
    end

    // Read-return pipeline and host error flag next values.
    always_comb begin
        rd_pend_d    = disp_grant;
        rd_oob_d     = disp_oob;
        disp_valid_d = rd_pend_q;
        disp_data_d  = rd_pend_q & ~rd_oob_q & mem_rdata;
        wr_err_d     = host_grant & wr_oob;
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            clr_val_q    <= 1'b0;
            clr_busy_q   <= 1'b0;
            clr_done_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_oob_q     <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clr_val_q    <= clr_val_d;
            clr_busy_q   <= clr_busy_d;
            clr_done_q   <= clr_done_d;
            rd_pend_q    <= rd_pend_d;
            rd_oob_q     <= rd_oob_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign wr_ready   = wr_ready_c;
    assign wr_err     = wr_err_q;
    assign clr_busy   = clr_busy_q;
    assign clr_done   = clr_done_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: table vectors, directed sequences and a randomized run,
// all checked against a buffer-level reference model.
module tb_fb_arbiter;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int AW  = 6;
    localparam int BUF = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid, disp_data;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic          wr_data, wr_err;
    logic          clr_start, clr_value, clr_busy, clr_done;
    logic          mem_en, mem_we, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rdata;

    fb_arbiter #(.VGA_WIDTH(W), .VGA_HEIGHT(H), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_err(wr_err),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural 1-cycle-latency single-port RAM.
    logic ram [0:63];
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 1'b0;
        mem_rdata = 1'b0;
    end
    always @(posedge clk) begin
        if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata     <= ram[mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: expected buffer contents, clear progress, read returns.
    bit ref_mem [0:BUF-1];
    int m_left;
    bit m_val, m_done, m_err;
    bit p1v, p1d, p2v, p2d;

    // Values sampled from the DUT in the most recent step.
    logic s_ready, s_busy, s_done, s_err, s_valid, s_data, s_we;
    logic [AW-1:0] s_waddr;

    // One clock cycle: check DUT against model, cross the edge, advance model.
    task automatic step();
        bit e_ready, acc, nerr, ndone, rd_d;
        #1;
        e_ready = !rst && m_left == 0 && !m_done && !disp_req && !clr_start;
        chk("wr_ready", wr_ready, e_ready);
        chk("clr_busy", clr_busy, m_left != 0);
        chk("clr_done", clr_done, m_done);
        chk("wr_err", wr_err, m_err);
        chk("disp_valid", disp_valid, p2v);
        chk("disp_data", disp_data, p2d);
        s_ready = wr_ready; s_busy = clr_busy; s_done = clr_done; s_err = wr_err;
        s_valid = disp_valid; s_data = disp_data; s_we = mem_en & mem_we; s_waddr = mem_addr;
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_done = 0; m_err = 0;
            p1v = 0; p1d = 0; p2v = 0; p2d = 0;
        end else begin
            rd_d  = disp_req && int'(disp_addr) < BUF ? ref_mem[int'(disp_addr)] : 1'b0;
            acc   = e_ready && wr_valid;
            nerr  = acc && int'(wr_addr) >= BUF;
            if (acc && int'(wr_addr) < BUF) ref_mem[int'(wr_addr)] = wr_data;
            ndone = 0;
            if (m_left > 0) begin
                if (!disp_req) begin
                    ref_mem[BUF - m_left] = m_val;
                    m_left--;
                    if (m_left == 0) ndone = 1;
                end
            end else if (!m_done && clr_start) begin
                m_left = BUF;
                m_val  = clr_value;
            end
            m_done = ndone; m_err = nerr;
            p2v = p1v; p2d = p1d; p1v = disp_req; p1d = rd_d;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; disp_req = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0;
        wr_data = 0; clr_start = 0; clr_value = 0;
    endtask

    // Host writes value to every address, advancing on each handshake.
    task automatic host_fill(input bit value);
        int a = 0, cyc = 0;
        wr_valid = 1; wr_data = value;
        while (a < BUF && cyc < 200) begin
            wr_addr = AW'(a);
            step();
            cyc++;
            if (s_ready) a++;
        end
        wr_valid = 0;
        chk("fill_handshakes", a, BUF);
        chk("fill_cycles", cyc, BUF);
    endtask

    int c_busy, c_done_at, c_first_rdy;
    logic [AW-1:0] wq [$];
    logic dv [0:79];
    logic dd [0:79];

    // Launch a clear and run until just after clr_done (bounded).
    task automatic run_clear(input bit val, input bit contend);
        wq.delete();
        c_busy = 0; c_done_at = -1; c_first_rdy = -1;
        for (int i = 0; i < 80; i++) begin dv[i] = 0; dd[i] = 0; end
        clr_start = 1; clr_value = val;
        step();
        clr_start = 0;
        for (int t = 1; t < 80; t++) begin
            disp_req = 0;
            if (contend) begin
                case (t)
                    10: begin disp_req = 1; disp_addr = 6'd30; end
                    11: begin disp_req = 1; disp_addr = 6'd31; end
                    20: begin disp_req = 1; disp_addr = 6'd2;  end
                    25: begin disp_req = 1; disp_addr = 6'd3;  end
                    default: ;
                endcase
            end
            step();
            if (s_busy) c_busy++;
            if (s_done && c_done_at < 0) c_done_at = t;
            if (s_busy && s_we) wq.push_back(s_waddr);
            if (s_ready && wr_valid && c_first_rdy < 0) begin
                c_first_rdy = t;
                wr_valid = 0;
            end
            dv[t] = s_valid; dd[t] = s_data;
            if (c_done_at >= 0 && t > c_done_at + 1) break;
        end
        disp_req = 0;
    endtask

    function automatic int order_errors();
        int bad = 0;
        if (wq.size() != BUF) bad++;
        for (int i = 0; i < wq.size(); i++) if (int'(wq[i]) != i) bad++;
        return bad;
    endfunction

    function automatic int count_ram(input bit value);
        int n = 0;
        for (int i = 0; i < BUF; i++) if (ram[i] === value) n++;
        return n;
    endfunction

    typedef struct {
        logic rst, dr; logic [AW-1:0] da;
        logic wv; logic [AW-1:0] wa; logic wd, cs;
        logic en, we; logic [AW-1:0] addr; logic wdat, rdy;
    } vec_t;
    vec_t vecs [0:10];

    initial begin
        int fails_before, dones, bad;
        idle_inputs();
        rst = 1;
        for (int i = 0; i < BUF; i++) ref_mem[i] = 0;
        m_left = 0; m_val = 0; m_done = 0; m_err = 0;
        p1v = 0; p1d = 0; p2v = 0; p2d = 0;

        //            rst dr da    wv wa    wd cs | en we addr  wd rdy
        vecs[0]  = '{0, 0, 6'd0,  0, 6'd0,  0, 0,  0, 0, 6'd0,  0, 1};
        vecs[1]  = '{0, 1, 6'd5,  0, 6'd0,  0, 0,  1, 0, 6'd5,  0, 0};
        vecs[2]  = '{0, 1, 6'd31, 0, 6'd0,  0, 0,  1, 0, 6'd31, 0, 0};
        vecs[3]  = '{0, 1, 6'd32, 0, 6'd0,  0, 0,  0, 0, 6'd32, 0, 0};
        vecs[4]  = '{0, 0, 6'd0,  1, 6'd9,  1, 0,  1, 1, 6'd9,  1, 1};
        vecs[5]  = '{0, 0, 6'd0,  1, 6'd31, 0, 0,  1, 1, 6'd31, 0, 1};
        vecs[6]  = '{0, 0, 6'd0,  1, 6'd40, 1, 0,  0, 0, 6'd40, 1, 1};
        vecs[7]  = '{0, 1, 6'd7,  1, 6'd9,  1, 0,  1, 0, 6'd7,  0, 0};
        vecs[8]  = '{0, 0, 6'd0,  1, 6'd9,  1, 1,  0, 0, 6'd0,  0, 0};
        vecs[9]  = '{1, 1, 6'd5,  1, 6'd9,  1, 0,  0, 0, 6'd0,  0, 0};
        vecs[10] = '{0, 0, 6'd3,  0, 6'd17, 1, 0,  0, 0, 6'd0,  0, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        rst = 0;
        step();

        // Combinational grant vectors in IDLE; inputs withdrawn before the edge.
        for (int i = 0; i < 11; i++) begin
            rst = vecs[i].rst; disp_req = vecs[i].dr; disp_addr = vecs[i].da;
            wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            clr_start = vecs[i].cs;
            #1;
            chk($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].en);
            chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].we);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].wdat);
            chk($sformatf("vec%0d_wr_ready", i), wr_ready, vecs[i].rdy);
            idle_inputs();
            step();
        end

        // Host fill with ones, then an uncontended clear to zero.
        host_fill(1);
        step();
        chk("fill_ones", count_ram(1), BUF);
        run_clear(0, 0);
        chk("clr_busy_cycles", c_busy, BUF);
        chk("clr_done_cycle", c_done_at, BUF + 1);
        chk("clr_write_order", order_errors(), 0);
        chk("clr_zeros", count_ram(0), BUF);

        // RAM[6]=1, then display reads of 5,6,7 back to back.
        wr_valid = 1; wr_addr = 6'd6; wr_data = 1;
        step();
        chk("wr6_accept", s_ready, 1);
        wr_valid = 0;
        step();
        for (int i = 0; i < 6; i++) begin
            disp_req = (i < 3); disp_addr = AW'(5 + i);
            step();
            dv[i] = s_valid; dd[i] = s_data;
        end
        disp_req = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rd567_valid%0d", i), dv[i], (i >= 2 && i <= 4));
            chk($sformatf("rd567_data%0d", i), dd[i], (i == 3));
        end

        // Clear with four display cycles interleaved.
        host_fill(1);
        run_clear(0, 1);
        chk("cclr_busy_cycles", c_busy, BUF + 4);
        chk("cclr_done_cycle", c_done_at, BUF + 5);
        chk("cclr_write_order", order_errors(), 0);
        chk("cclr_rd30", {dv[12], dd[12]}, 2'b11);
        chk("cclr_rd31", {dv[13], dd[13]}, 2'b11);
        chk("cclr_rd2", {dv[22], dd[22]}, 2'b10);
        chk("cclr_rd3", {dv[27], dd[27]}, 2'b10);

        // Host write held through a clear lands after clr_done.
        wr_valid = 1; wr_addr = 6'd12; wr_data = 0;
        run_clear(1, 0);
        wr_valid = 0;
        chk("held_done_cycle", c_done_at, BUF + 1);
        chk("held_first_ready", c_first_rdy, BUF + 2);
        repeat (3) step();
        chk("held_ram12", ram[12], 0);
        chk("held_ram13", ram[13], 1);

        // Out-of-range host write.
        wr_valid = 1; wr_addr = 6'd40; wr_data = 1;
        step();
        chk("oob_accept", s_ready, 1);
        chk("oob_mem_we", s_we, 0);
        wr_valid = 0;
        step();
        chk("oob_wr_err", s_err, 1);
        step();
        chk("oob_wr_err_pulse", s_err, 0);

        // Reset at clear cycle 10.
        clr_start = 1; clr_value = 0;
        step();
        clr_start = 0;
        for (int t = 1; t < 10; t++) step();
        rst = 1;
        step();
        rst = 0;
        step();
        chk("rstclr_busy", s_busy, 0);
        dones = 0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (s_done) dones++;
        end
        chk("rstclr_no_done", dones, 0);

        // Randomized traffic against the model.
        fails_before = failures;
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(499) == 0);
            disp_req  = ($urandom_range(9) < 3);
            disp_addr = AW'($urandom_range(39));
            wr_valid  = ($urandom_range(1) == 1);
            wr_addr   = AW'($urandom_range(35));
            wr_data   = 1'($urandom_range(1));
            clr_start = ($urandom_range(149) == 0);
            clr_value = 1'($urandom_range(1));
            step();
            if (failures - fails_before > 20) break;
        end
        idle_inputs();
        repeat (40) step();
        bad = 0;
        for (int i = 0; i < BUF; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_vs_model", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
